// File: rtl/unidade_controle_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg: shared definitions for the unidade_controle control unit.
//   - word/register/opcode widths
//   - instruction opcodes (same values the ULA decodes)
//   - step encoding T0..T3
//   - instruction field bit positions
// -----------------------------------------------------------------------------
package ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int OPC_W  = 4;

    // Opcodes; the arithmetic ones are passed straight through to the ULA.
    localparam logic [OPC_W-1:0] OP_LD   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ST   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_MVNZ = 4'b0010;
    localparam logic [OPC_W-1:0] OP_MV   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_MVI  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0111;
    localparam logic [OPC_W-1:0] OP_SLT  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SLL  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_SLR  = 4'b1010;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    // Instruction field positions: opcode | Rx | Ry | unused[5:0]
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RX_MSB  = 11;
    localparam int RX_LSB  = 9;
    localparam int RY_MSB  = 8;
    localparam int RY_LSB  = 6;

endpackage

// File: rtl/unidade_controle_if.sv
// -----------------------------------------------------------------------------
// unidade_controle_if: control-unit <-> datapath signal bundle.
//   master : datapath side (drives Run, DIN, GZero; receives the strobes)
//   slave  : control unit  (receives Run, DIN, GZero; drives the strobes)
// -----------------------------------------------------------------------------
interface unidade_controle_if;
    import ctrl_pkg::*;

    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              GZero;

    logic              IRin;
    logic [NREG-1:0]   Rout;
    logic [NREG-1:0]   Rin;
    logic              DINout;
    logic              Gout;
    logic              Ain;
    logic              Gin;
    logic [OPC_W-1:0]  ULAOp;
    logic              ADDRin;
    logic              DOUTin;
    logic              W_D;
    logic              Done;

    modport master (
        output Run, DIN, GZero,
        input  IRin, Rout, Rin, DINout, Gout, Ain, Gin, ULAOp,
               ADDRin, DOUTin, W_D, Done
    );

    modport slave (
        input  Run, DIN, GZero,
        output IRin, Rout, Rin, DINout, Gout, Ain, Gin, ULAOp,
               ADDRin, DOUTin, W_D, Done
    );

endinterface

// File: rtl/unidade_controle_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8: 3-to-8 one-hot decoder with enable.
//   en  : when low, y is all zeros
//   sel : register index
//   y   : one-hot output, bit sel set when enabled
// -----------------------------------------------------------------------------
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    assign y = en ? (8'b0000_0001 << sel) : 8'b0000_0000;

endmodule

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle: multi-cycle control FSM for the 16-bit simple processor.
// Latches the instruction from DIN in T0 (when Run) and sequences T1..T3,
// driving the datapath strobes through the interface (slave side).
//   Clock : rising-edge system clock
//   Reset : synchronous, active-high; forces every output low while high
//   bus   : Run/DIN/GZero in; IRin, Rout, Rin, DINout, Gout, Ain, Gin,
//           ULAOp, ADDRin, DOUTin, W_D, Done out
// All outputs are combinational from Tstep, IR, Run and GZero.
// -----------------------------------------------------------------------------
module unidade_controle
    import ctrl_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    unidade_controle_if.slave  bus
);

    step_t             Tstep;
    logic [DATA_W-1:0] IR;

    logic [OPC_W-1:0]  opcode;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [NREG-1:0]   rx_oh;
    logic [NREG-1:0]   ry_oh;

    // Per-step micro-controls; the Rx/Ry selects are expanded to one-hot below.
    logic rout_rx, rout_ry, rin_rx;
    logic irin, dinout, gout, ain, gin, addrin, doutin, wd, done;

    assign opcode = IR[OPC_MSB:OPC_LSB];
    assign rx     = IR[RX_MSB:RX_LSB];
    assign ry     = IR[RY_MSB:RY_LSB];

    dec3to8 u_dec_rx (.en(~Reset), .sel(rx), .y(rx_oh));
    dec3to8 u_dec_ry (.en(~Reset), .sel(ry), .y(ry_oh));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        rout_rx = 1'b0;
        rout_ry = 1'b0;
        rin_rx  = 1'b0;
        irin    = 1'b0;
        dinout  = 1'b0;
        gout    = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        addrin  = 1'b0;
        doutin  = 1'b0;
        wd      = 1'b0;
        done    = 1'b0;
        if (!Reset) begin
            case (Tstep)
                T0: irin = bus.Run;
                T1: begin
                    case (opcode)
                        OP_MV: begin
                            rout_ry = 1'b1;
                            rin_rx  = 1'b1;
                            done    = 1'b1;
                        end
                        OP_MVI: begin
                            dinout = 1'b1;
                            rin_rx = 1'b1;
                            done   = 1'b1;
                        end
                        OP_MVNZ: begin
                            // The move is suppressed when G is zero; the instruction still ends here.
                            rout_ry = ~bus.GZero;
                            rin_rx  = ~bus.GZero;
                            done    = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SLR: begin
                            rout_rx = 1'b1;
                            ain     = 1'b1;
                        end
                        OP_LD, OP_ST: begin
                            rout_ry = 1'b1;
                            addrin  = 1'b1;
                        end
                        // Illegal opcodes retire immediately with no side effects.
                        default: done = 1'b1;
                    endcase
                end
                T2: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SLR: begin
                            rout_ry = 1'b1;
                            gin     = 1'b1;
                        end
                        OP_ST: begin
                            rout_rx = 1'b1;
                            doutin  = 1'b1;
                            wd      = 1'b1;
                            done    = 1'b1;
                        end
                        // ld waits here for the memory read data.
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SLR: begin
                            gout   = 1'b1;
                            rin_rx = 1'b1;
                            done   = 1'b1;
                        end
                        OP_LD: begin
                            dinout = 1'b1;
                            rin_rx = 1'b1;
                            done   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.IRin   = irin;
    assign bus.Rout   = ({NREG{rout_rx}} & rx_oh) | ({NREG{rout_ry}} & ry_oh);
    assign bus.Rin    = {NREG{rin_rx}} & rx_oh;
    assign bus.DINout = dinout;
    assign bus.Gout   = gout;
    assign bus.Ain    = ain;
    assign bus.Gin    = gin;
    assign bus.ULAOp  = Reset ? '0 : opcode;
    assign bus.ADDRin = addrin;
    assign bus.DOUTin = doutin;
    assign bus.W_D    = wd;
    assign bus.Done   = done;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Tstep <= T0;
            IR    <= '0;
        end else if (Tstep == T0) begin
            if (bus.Run) begin
                IR    <= bus.DIN;
                Tstep <= T1;
            end
        end else if (done) begin
            Tstep <= T0;
        end else begin
            Tstep <= step_t'(Tstep + 2'd1);
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle: self-checking bench for unidade_controle.
// A register-transfer level model predicts every output each cycle; a compare
// process checks it on the falling edge, alongside literal spot checks.
// -----------------------------------------------------------------------------
module tb_unidade_controle;
    import ctrl_pkg::*;

    logic Clock;
    logic Reset;

    unidade_controle_if bus_if ();

    unidade_controle dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit running  = 1'b1;

    typedef struct packed {
        logic       irin;
        logic [7:0] rout;
        logic [7:0] rin;
        logic       dinout;
        logic       gout;
        logic       ain;
        logic       gin;
        logic [3:0] ulaop;
        logic       addrin;
        logic       doutin;
        logic       wd;
        logic       done;
    } outs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.irin   = bus_if.IRin;
        o.rout   = bus_if.Rout;
        o.rin    = bus_if.Rin;
        o.dinout = bus_if.DINout;
        o.gout   = bus_if.Gout;
        o.ain    = bus_if.Ain;
        o.gin    = bus_if.Gin;
        o.ulaop  = bus_if.ULAOp;
        o.addrin = bus_if.ADDRin;
        o.doutin = bus_if.DOUTin;
        o.wd     = bus_if.W_D;
        o.done   = bus_if.Done;
        return o;
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {SRC_NONE, SRC_RX, SRC_RY, SRC_DIN, SRC_G} src_e;

    function automatic bit is_alu(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SLR};
    endfunction

    function automatic int nsteps(input logic [3:0] op);
        if (is_alu(op) || op == OP_LD) return 3;
        if (op == OP_ST) return 2;
        return 1;
    endfunction

    // Expected outputs, described as one bus transfer plus side strobes per step.
    function automatic outs_t exp_outs(input bit rst, input bit act, input logic [15:0] ir,
                                       input int k, input bit run, input bit gz);
        outs_t o;
        src_e  src;
        bit    wr_rx;
        logic [3:0] op;
        int rx, ry;
        o = '0;
        if (rst) return o;
        op = ir[15:12];
        rx = int'(ir[11:9]);
        ry = int'(ir[8:6]);
        o.ulaop = op;
        if (!act) begin
            o.irin = run;
            return o;
        end
        src   = SRC_NONE;
        wr_rx = 1'b0;
        o.done = (k == nsteps(op));
        if (is_alu(op)) begin
            if (k == 1) begin src = SRC_RX; o.ain = 1'b1; end
            if (k == 2) begin src = SRC_RY; o.gin = 1'b1; end
            if (k == 3) begin src = SRC_G;  wr_rx = 1'b1; end
        end else if (op == OP_LD) begin
            if (k == 1) begin src = SRC_RY;  o.addrin = 1'b1; end
            if (k == 3) begin src = SRC_DIN; wr_rx = 1'b1; end
        end else if (op == OP_ST) begin
            if (k == 1) begin src = SRC_RY; o.addrin = 1'b1; end
            if (k == 2) begin src = SRC_RX; o.doutin = 1'b1; o.wd = 1'b1; end
        end else if (op == OP_MV) begin
            src = SRC_RY; wr_rx = 1'b1;
        end else if (op == OP_MVI) begin
            src = SRC_DIN; wr_rx = 1'b1;
        end else if (op == OP_MVNZ) begin
            if (!gz) begin src = SRC_RY; wr_rx = 1'b1; end
        end
        case (src)
            SRC_RX:  o.rout[rx] = 1'b1;
            SRC_RY:  o.rout[ry] = 1'b1;
            SRC_DIN: o.dinout   = 1'b1;
            SRC_G:   o.gout     = 1'b1;
            default: ;
        endcase
        if (wr_rx) o.rin[rx] = 1'b1;
        return o;
    endfunction

    bit          m_act = 1'b0;
    logic [15:0] m_ir  = '0;
    int          m_k   = 0;

    always @(posedge Clock) begin
        if (Reset) begin
            m_act = 1'b0;
            m_ir  = '0;
        end else if (!m_act) begin
            if (bus_if.Run) begin
                m_ir  = bus_if.DIN;
                m_act = 1'b1;
                m_k   = 1;
            end
        end else if (m_k == nsteps(m_ir[15:12])) begin
            m_act = 1'b0;
        end else begin
            m_k++;
        end
    end

    always @(negedge Clock) begin
        if (running) begin
            outs_t a;
            outs_t e;
            a = dut_outs();
            e = exp_outs(Reset, m_act, m_ir, m_k, bus_if.Run, bus_if.GZero);
            check("model", 32'(a), 32'(e));
            check("bus_onehot", 32'($countones(a.rout) + int'(a.dinout) + int'(a.gout) <= 1), 32'd1);
            check("rin_onehot", 32'($countones(a.rin) <= 1), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit rst, input bit run, input logic [15:0] din, input bit gz);
        @(posedge Clock);
        #1;
        Reset        = rst;
        bus_if.Run   = run;
        bus_if.DIN   = din;
        bus_if.GZero = gz;
    endtask

    task automatic at_neg();
        @(negedge Clock);
    endtask

    initial begin
        logic [15:0] seq [3];
        Reset        = 1'b1;
        bus_if.Run   = 1'b0;
        bus_if.DIN   = '0;
        bus_if.GZero = 1'b0;

        // Reset and idle
        tick(1, 0, 16'h0000, 0);
        tick(1, 0, 16'h0000, 0);
        at_neg(); check("reset_outs", 32'(dut_outs()), 32'd0);
        tick(0, 0, 16'h0000, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg(); check("idle_outs", 32'(dut_outs()), 32'd0);

        // mvi R2, #5
        tick(0, 1, 16'h4400, 0);
        at_neg(); check("mvi_irin", 32'(bus_if.IRin), 32'd1);
        tick(0, 0, 16'h0005, 0);
        at_neg();
        check("mvi_dinout", 32'(bus_if.DINout), 32'd1);
        check("mvi_rin", 32'(bus_if.Rin), 32'h04);
        check("mvi_done", 32'(bus_if.Done), 32'd1);

        // add R1, R2
        tick(0, 1, 16'h5280, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("add_t1_rout", 32'(bus_if.Rout), 32'h02);
        check("add_t1_ain", 32'(bus_if.Ain), 32'd1);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("add_t2_rout", 32'(bus_if.Rout), 32'h04);
        check("add_t2_gin", 32'(bus_if.Gin), 32'd1);
        check("add_t2_ulaop", 32'(bus_if.ULAOp), 32'h5);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("add_t3_gout", 32'(bus_if.Gout), 32'd1);
        check("add_t3_rin", 32'(bus_if.Rin), 32'h02);
        check("add_t3_done", 32'(bus_if.Done), 32'd1);

        // mvnz R3, R1 with G == 0, then G != 0
        tick(0, 1, 16'h2640, 1);
        tick(0, 0, 16'h0000, 1);
        at_neg();
        check("mvnz_gz1_rin", 32'(bus_if.Rin), 32'h00);
        check("mvnz_gz1_rout", 32'(bus_if.Rout), 32'h00);
        check("mvnz_gz1_done", 32'(bus_if.Done), 32'd1);
        tick(0, 1, 16'h2640, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("mvnz_gz0_rout", 32'(bus_if.Rout), 32'h02);
        check("mvnz_gz0_rin", 32'(bus_if.Rin), 32'h08);

        // ld R0, [R5]
        tick(0, 1, 16'h0140, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg(); check("ld_t1_rout", 32'(bus_if.Rout), 32'h20);
        tick(0, 0, 16'h0000, 0);
        at_neg(); check("ld_t2_done", 32'(bus_if.Done), 32'd0);
        tick(0, 0, 16'h1234, 0);
        at_neg();
        check("ld_t3_done", 32'(bus_if.Done), 32'd1);
        check("ld_t3_dinout", 32'(bus_if.DINout), 32'd1);
        check("ld_t3_rin", 32'(bus_if.Rin), 32'h01);

        // st R4, [R6]
        tick(0, 1, 16'h1980, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg(); check("st_t1_rout", 32'(bus_if.Rout), 32'h40);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("st_t2_rout", 32'(bus_if.Rout), 32'h10);
        check("st_t2_doutin", 32'(bus_if.DOUTin), 32'd1);
        check("st_t2_wd", 32'(bus_if.W_D), 32'd1);
        check("st_t2_done", 32'(bus_if.Done), 32'd1);

        // Illegal opcode
        tick(0, 1, 16'hF000, 0);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("ill_done", 32'(bus_if.Done), 32'd1);
        check("ill_rin", 32'(bus_if.Rin), 32'h00);
        check("ill_wd", 32'(bus_if.W_D), 32'd0);

        // Back-to-back sll R3,R4 / slr R5,R6 / slt R7,R0 with Run held high
        seq[0] = 16'h9700;
        seq[1] = 16'hAB80;
        seq[2] = 16'h8E00;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, seq[i], 0);
            at_neg(); check("b2b_irin", 32'(bus_if.IRin), 32'd1);
            for (int j = 0; j < 3; j++) tick(0, 1, 16'hFFFF, 0);
            at_neg(); check("b2b_done", 32'(bus_if.Done), 32'd1);
        end
        tick(0, 1, 16'h0000, 0);
        at_neg(); check("b2b_next_irin", 32'(bus_if.IRin), 32'd1);
        tick(0, 0, 16'h0000, 0);

        // Reset in T2 of add R1, R2
        tick(0, 1, 16'h5280, 0);
        tick(0, 0, 16'h0000, 0);
        tick(1, 0, 16'h0000, 0);
        at_neg(); check("rst_t2_outs", 32'(dut_outs()), 32'd0);
        tick(0, 0, 16'h0000, 0);
        at_neg();
        check("rst_after_outs", 32'(dut_outs()), 32'd0);
        check("rst_after_done", 32'(bus_if.Done), 32'd0);
        tick(0, 0, 16'h0000, 0);
        at_neg();

        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
